// File: rtl/wiener_multi_channel.sv
`default_nettype none
// ============================================================================
// wiener_multi_channel: N-channel block-adaptive Wiener filter. Buffers a block,
// derives per-channel gain from block statistics, replays the block filtered.
// Optional feature macro: WIENER_BYPASS_EN (adds bypass input, forces unity gain).
// Revision: 1.0
// ============================================================================
module wiener_multi_channel #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CHANNELS  = 3,
  parameter int TOTAL_SAMPLES = 64,
  parameter int GAIN_BITS     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] noise_variance,
`ifdef WIENER_BYPASS_EN
  input  logic                                 bypass,
`endif
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   out_data,
  output logic                                 out_last,
  output logic [31:0]                          block_count,
  output logic                                 busy
);
  localparam int LOG2_S = $clog2(TOTAL_SAMPLES);
  localparam int SW     = DATA_WIDTH + LOG2_S;
  localparam int QW     = 2*DATA_WIDTH + LOG2_S;
  localparam int VW     = 2*DATA_WIDTH;
  localparam int GW     = GAIN_BITS + 1;
  localparam int CW     = $clog2(GW) + 1;
  localparam int PW     = GW + DATA_WIDTH + 2;
  localparam int PXW    = NUM_CHANNELS*DATA_WIDTH;
  localparam logic [LOG2_S-1:0] LAST_IDX = LOG2_S'(TOTAL_SAMPLES-1);

  typedef enum logic [2:0] {IDLE, COLLECT, STATS, DIVIDE, OUTPUT} state_t;

  state_t            state, next_state;
  logic [LOG2_S-1:0] wr_idx, rd_idx;
  logic [CW-1:0]     div_cnt;
  logic [PXW-1:0]    mem [TOTAL_SAMPLES];
  logic [PXW-1:0]    rd_word;
  logic              accept, last_emit;

  assign accept    = in_valid && in_ready;
  assign last_emit = out_valid && out_ready && (rd_idx == LAST_IDX);
  assign rd_word   = mem[rd_idx];

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) next_state = COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (accept && wr_idx == LAST_IDX) next_state = STATS;
      end
      STATS:  next_state = DIVIDE;
      DIVIDE: if (div_cnt == CW'(GAIN_BITS)) next_state = OUTPUT;
      OUTPUT: begin
        out_valid = 1'b1;
        out_last  = (rd_idx == LAST_IDX);
        if (last_emit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_idx      <= '0;
      rd_idx      <= '0;
      div_cnt     <= '0;
      block_count <= '0;
    end else begin
      state <= next_state;
      if (accept) wr_idx <= wr_idx + LOG2_S'(1);
      if (out_valid && out_ready) rd_idx <= rd_idx + LOG2_S'(1);
      if (state == DIVIDE) div_cnt <= div_cnt + CW'(1);
      else                 div_cnt <= '0;
      // A coincident frame_start wins over the completion increment.
      if (frame_start)    block_count <= '0;
      else if (last_emit) block_count <= block_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_idx] <= in_data;
  end

`ifdef WIENER_BYPASS_EN
  logic bypass_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 bypass_r <= 1'b0;
    else if (state == STATS) bypass_r <= bypass;
  end
`endif

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [SW-1:0]         sum;
    logic [QW-1:0]         sumsq;
    logic [DATA_WIDTH-1:0] mean_r, mean_c, xin, x;
    logic [VW-1:0]         var_r, var_c, ms, msq, noise_c;
    logic [VW:0]           rem;
    logic [GW-1:0]         quot, gain;
    logic                  pos_r;
    logic signed [PW-1:0]  dev, prod, filt;

    assign xin     = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign x       = rd_word[c*DATA_WIDTH +: DATA_WIDTH];
    assign noise_c = noise_variance[c*VW +: VW];
    assign mean_c  = sum[SW-1:LOG2_S];
    assign ms      = sumsq[QW-1:LOG2_S];
    assign msq     = VW'(mean_c) * VW'(mean_c);
    assign var_c   = (ms > msq) ? ms - msq : '0;

`ifdef WIENER_BYPASS_EN
    assign gain = bypass_r ? {1'b1, {GAIN_BITS{1'b0}}} : quot;
`else
    assign gain = quot;
`endif

    assign dev  = $signed({{(PW-DATA_WIDTH){1'b0}}, x}) - $signed({{(PW-DATA_WIDTH){1'b0}}, mean_r});
    assign prod = dev * $signed({{(PW-GW){1'b0}}, gain});
    assign filt = $signed({{(PW-DATA_WIDTH){1'b0}}, mean_r}) + (prod >>> GAIN_BITS);

    always_comb begin
      out_data[c*DATA_WIDTH +: DATA_WIDTH] = '0;
      if (out_valid) begin
        if (filt < 0)
          out_data[c*DATA_WIDTH +: DATA_WIDTH] = '0;
        else if (filt > $signed({{(PW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}}))
          out_data[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b1}};
        else
          out_data[c*DATA_WIDTH +: DATA_WIDTH] = filt[DATA_WIDTH-1:0];
      end
    end

    // Restoring division yields one quotient bit per cycle, integer bit first;
    // pos_r masks the var<=noise case (including var=0) to a zero gain.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum    <= '0;
        sumsq  <= '0;
        mean_r <= '0;
        var_r  <= '0;
        pos_r  <= 1'b0;
        rem    <= '0;
        quot   <= '0;
      end else begin
        case (state)
          IDLE, COLLECT: begin
            if (accept) begin
              if (state == IDLE) begin
                sum   <= SW'(xin);
                sumsq <= QW'(VW'(xin) * VW'(xin));
              end else begin
                sum   <= sum + SW'(xin);
                sumsq <= sumsq + QW'(VW'(xin) * VW'(xin));
              end
            end
          end
          STATS: begin
            mean_r <= mean_c;
            var_r  <= var_c;
            pos_r  <= (var_c > noise_c);
            rem    <= (var_c > noise_c) ? {1'b0, var_c - noise_c} : '0;
            quot   <= '0;
          end
          DIVIDE: begin
            if (pos_r && rem >= {1'b0, var_r}) begin
              rem  <= (rem - {1'b0, var_r}) << 1;
              quot <= {quot[GW-2:0], 1'b1};
            end else begin
              rem  <= rem << 1;
              quot <= {quot[GW-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
